// File: rtl/fsk_pkg.sv
// Shared FSK path definitions: symbol FSM states and default tone/symbol timing.
package fsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_DIV_MARK  = 4;
    localparam int DEF_DIV_SPACE = 16;
    localparam int DEF_SYM_CLKS  = 64;
    localparam int DEF_CNT_W     = 14;

endpackage

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: half-period counter toggling fsk_out, mark/space selected by div_sel.
module fsk_tone_gen
    import fsk_pkg::*;
#(
    parameter int DIV_MARK  = DEF_DIV_MARK,
    parameter int DIV_SPACE = DEF_DIV_SPACE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic div_sel,
    input  logic restart,
    input  logic enable,
    output logic fsk_out
);

    localparam logic [CNT_W-1:0] HALF_M = CNT_W'(DIV_MARK / 2 - 1);
    localparam logic [CNT_W-1:0] HALF_S = CNT_W'(DIV_SPACE / 2 - 1);

    logic [CNT_W-1:0] tone_cnt;
    logic [CNT_W-1:0] half;

    assign half = div_sel ? HALF_M : HALF_S;

    // A restart only clears the phase counter; a coincident toggle still lands on fsk_out.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            fsk_out  <= 1'b0;
        end else if (!enable) begin
            tone_cnt <= '0;
            fsk_out  <= 1'b0;
        end else begin
            if (tone_cnt == half) begin
                fsk_out  <= ~fsk_out;
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
            if (restart) tone_cnt <= '0;
        end
    end

endmodule

// File: rtl/fsk_mod.sv
// 2FSK modulator: one-entry bit buffer, symbol-timing FSM and a mark/space tone generator.
module fsk_mod
    import fsk_pkg::*;
#(
    parameter int DIV_MARK  = DEF_DIV_MARK,
    parameter int DIV_SPACE = DEF_DIV_SPACE,
    parameter int SYM_CLKS  = DEF_SYM_CLKS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    output logic fsk_out,
    output logic sym_strobe,
    output logic busy,
    output logic underrun
);

    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CLKS - 1);

    state_t           state, state_nxt;
    logic             buf_bit, buf_full, cur_bit;
    logic [CNT_W-1:0] sym_cnt;
    logic             sym_end, load, accept, tone_en;

    assign sym_end = (state == SEND) && (sym_cnt == SYM_LAST);
    assign load    = buf_full && ((state == IDLE) || sym_end);
    assign accept  = bit_valid && !buf_full;
    assign tone_en = (state == SEND) && !(sym_end && !buf_full);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_full) state_nxt = SEND;
            SEND:    if (sym_end && !buf_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == SEND);
        sym_strobe = (state == SEND) && (sym_cnt == '0);
        bit_ready  = !buf_full;
    end

    // Load needs a full buffer and accept needs an empty one, so they never share an edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_bit  <= 1'b0;
            cur_bit  <= 1'b0;
            sym_cnt  <= '0;
            underrun <= 1'b0;
        end else begin
            if (load) begin
                buf_full <= 1'b0;
                cur_bit  <= buf_bit;
            end else if (accept) begin
                buf_full <= 1'b1;
                buf_bit  <= bit_in;
            end
            if (load || sym_end)     sym_cnt <= '0;
            else if (state == SEND)  sym_cnt <= sym_cnt + 1'b1;
            underrun <= sym_end && !buf_full;
        end
    end

    fsk_tone_gen #(
        .DIV_MARK  (DIV_MARK),
        .DIV_SPACE (DIV_SPACE),
        .CNT_W     (CNT_W)
    ) u_tone (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .div_sel (cur_bit),
        .restart (sym_end),
        .enable  (tone_en),
        .fsk_out (fsk_out)
    );

endmodule

// File: tb/tb_fsk_mod.sv
// Directed bench for fsk_mod: default timing instance plus a short-symbol instance.
module tb_fsk_mod;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic bit_in = 1'b0, bit_valid = 1'b0;
    logic bit_ready, fsk_out, sym_strobe, busy, underrun;
    logic bit_in2 = 1'b0, bit_valid2 = 1'b0;
    logic bit_ready2, fsk_out2, sym_strobe2, busy2, underrun2;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    bit src_q[$];
    bit sb_q[$];

    always #5 clk_in = ~clk_in;

    fsk_mod dut (
        .clk_in(clk_in), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .fsk_out(fsk_out), .sym_strobe(sym_strobe),
        .busy(busy), .underrun(underrun)
    );

    fsk_mod #(.DIV_MARK(2), .DIV_SPACE(8), .SYM_CLKS(2), .CNT_W(14)) dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .bit_in(bit_in2), .bit_valid(bit_valid2),
        .bit_ready(bit_ready2), .fsk_out(fsk_out2), .sym_strobe(sym_strobe2),
        .busy(busy2), .underrun(underrun2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source: presents the head of src_q at each falling edge.
    initial forever begin
        @(negedge clk_in);
        if (src_q.size() > 0) begin
            bit_valid = 1'b1;
            bit_in    = src_q[0];
        end else begin
            bit_valid = 1'b0;
        end
    end

    // Accept monitor feeding the scoreboard.
    initial forever begin
        @(posedge clk_in);
        if (rst_n && bit_valid && bit_ready) begin
            sb_q.push_back(bit_in);
            void'(src_q.pop_front());
            acc_cnt++;
        end
    end

    task automatic wait_strobe(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (sym_strobe) break;
        end
        check({tag, "_strobe_seen"}, sym_strobe, 1);
    endtask

    task automatic run_stream(input string tag, input int n, input logic [7:0] pat);
        int  a0, tr, first;
        logic prev;
        for (int k = 0; k < n; k++) src_q.push_back(pat[k]);
        wait_strobe(tag);
        for (int k = 0; k < n; k++) begin
            check({tag, "_busy"}, busy, 1);
            a0 = acc_cnt; tr = 0; first = 0; prev = fsk_out;
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk_in);
                if (fsk_out !== prev) begin
                    tr++;
                    if (first == 0) first = i;
                end
                prev = fsk_out;
                if (i == 1) check({tag, "_ready_held"}, bit_ready, (k < n - 1) ? 0 : 1);
            end
            check({tag, "_first_toggle"}, first, pat[k] ? 2 : 8);
            check({tag, "_toggles"}, tr, pat[k] ? 32 : 8);
            check({tag, "_accepts"}, acc_cnt - a0, (k < n - 1) ? 1 : 0);
            if (k < n - 1) begin
                check({tag, "_no_gap"}, sym_strobe, 1);
            end else begin
                check({tag, "_underrun"}, underrun, 1);
                check({tag, "_idle_busy"}, busy, 0);
                check({tag, "_idle_out"}, fsk_out, 0);
            end
        end
        check({tag, "_sb_size"}, sb_q.size(), n);
        for (int k = 0; k < n && k < sb_q.size(); k++)
            check({tag, "_sb_bit"}, sb_q[k], pat[k]);
        sb_q.delete();
        @(negedge clk_in);
        check({tag, "_underrun_1cyc"}, underrun, 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk_in);
        check("rst_out", fsk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bit_ready, 1);
        check("rst_strobe", sym_strobe, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (fsk_out !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);

        run_stream("single", 1, 8'b1);
        run_stream("stream", 3, 8'b101);
        run_stream("bp", 5, 8'b01101);

        // Asynchronous reset mid-symbol with the buffer full.
        src_q.push_back(1'b1);
        src_q.push_back(1'b0);
        wait_strobe("mid");
        repeat (30) @(negedge clk_in);
        check("mid_buf_full", bit_ready, 0);
        #2 rst_n = 1'b0;
        src_q.delete();
        #1;
        check("mid_rst_out", fsk_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", bit_ready, 1);
        check("mid_rst_strobe", sym_strobe, 0);
        sb_q.delete();
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (busy !== 1'b0 || fsk_out !== 1'b0 || sym_strobe !== 1'b0) bad++;
        end
        check("mid_after_quiet", bad, 0);

        // Short-symbol instance: bits 1,1 back to back, toggle coincides with symbol end.
        bit_valid2 = 1'b1; bit_in2 = 1'b1;
        @(negedge clk_in);
        check("p2_ready_full", bit_ready2, 0);
        @(negedge clk_in);
        check("p2_strobe_a", sym_strobe2, 1);
        check("p2_out_a0", fsk_out2, 0);
        @(negedge clk_in);
        check("p2_out_a1", fsk_out2, 1);
        bit_valid2 = 1'b0;
        @(negedge clk_in);
        check("p2_strobe_b", sym_strobe2, 1);
        check("p2_out_b0", fsk_out2, 0);
        @(negedge clk_in);
        check("p2_out_b1", fsk_out2, 1);
        @(negedge clk_in);
        check("p2_underrun_b", underrun2, 1);
        check("p2_end_out_b", fsk_out2, 0);
        check("p2_end_busy_b", busy2, 0);

        // Bits 0 then 1: the mark symbol must start with a cleared tone counter.
        @(negedge clk_in);
        bit_valid2 = 1'b1; bit_in2 = 1'b0;
        @(negedge clk_in);
        check("p2_busy_pre", busy2, 0);
        bit_in2 = 1'b1;
        @(negedge clk_in);
        check("p2_strobe_0", sym_strobe2, 1);
        check("p2_ready_0", bit_ready2, 1);
        @(negedge clk_in);
        check("p2_ready_1", bit_ready2, 0);
        check("p2_out_s1", fsk_out2, 0);
        bit_valid2 = 1'b0;
        @(negedge clk_in);
        check("p2_strobe_1", sym_strobe2, 1);
        check("p2_out_m0", fsk_out2, 0);
        @(negedge clk_in);
        check("p2_out_m1", fsk_out2, 1);
        @(negedge clk_in);
        check("p2_underrun", underrun2, 1);
        check("p2_end_out", fsk_out2, 0);
        check("p2_end_busy", busy2, 0);
        @(negedge clk_in);
        check("p2_underrun_clr", underrun2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
